// File: rtl/fb_raw_pixel_unpack.sv
// Re-packs raw frame-buffer words into per-port pixel beats through a byte residue
// buffer, so pixel sizes that do not divide the word width are handled.
module fb_raw_pixel_unpack #(
    parameter int C_RAW_DATA_WIDTH         = 256,
    parameter int C_MAX_PORT_NUM           = 4,
    parameter int C_DDR_PIXEL_MAX_BYTE_NUM = 4
) (
    input  logic                                               VID_CLK_I,
    input  logic                                               VID_RSTN_I,
    input  logic [3:0]                                         CFG_PORT_NUM_I,
    input  logic [2:0]                                         CFG_MEM_BYTES_I,
    input  logic                                               SOF_I,
    input  logic [C_RAW_DATA_WIDTH-1:0]                        RAW_DATA_I,
    input  logic                                               RAW_VALID_I,
    output logic                                               RAW_READY_O,
    input  logic                                               PIX_REQ_I,
    output logic [C_DDR_PIXEL_MAX_BYTE_NUM*8*C_MAX_PORT_NUM-1:0] PIX_DATA_O,
    output logic                                               PIX_VALID_O,
    output logic                                               UNDERFLOW_O
);

    localparam int RB    = C_RAW_DATA_WIDTH / 8;
    localparam int DEPTH = 2 * RB;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LW    = C_DDR_PIXEL_MAX_BYTE_NUM * 8;
    localparam int OW    = LW * C_MAX_PORT_NUM;

    logic [7:0]    byteBuf_q [DEPTH];
    logic [7:0]    byteBuf_d [DEPTH];
    logic [7:0]    rawBytes  [RB];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    portNum_q, portNum_d;
    logic [2:0]    memBytes_q, memBytes_d;
    logic [OW-1:0] pixData_q, pixData_d;
    logic          pixValid_q, pixValid_d;
    logic          underflow_q, underflow_d;

    logic [CW-1:0] beatN;
    logic [CW-1:0] base;
    logic          accept;
    logic          consume;
    int            nInt;
    int            baseInt;

    assign beatN       = CW'(portNum_q) * CW'(memBytes_q);
    assign RAW_READY_O = (cnt_q <= CW'(RB)) & ~SOF_I;
    assign accept      = RAW_VALID_I & RAW_READY_O;
    assign consume     = PIX_REQ_I & ~SOF_I & (cnt_q >= beatN);
    assign base        = consume ? (cnt_q - beatN) : cnt_q;

    always_comb begin
        for (int b = 0; b < RB; b++) begin
            rawBytes[b] = RAW_DATA_I[b*8 +: 8];
        end
    end

    // Residue buffer: drop the consumed beat first, then append the new word
    // right behind whatever residue survives the shift.
    always_comb begin
        nInt    = int'(beatN);
        baseInt = int'(base);
        for (int i = 0; i < DEPTH; i++) begin
            byteBuf_d[i] = byteBuf_q[i];
            if (consume) begin
                if (i + nInt < DEPTH) begin
                    byteBuf_d[i] = byteBuf_q[AW'(i + nInt)];
                end else begin
                    byteBuf_d[i] = '0;
                end
            end
            if (accept && (i >= baseInt) && (i < baseInt + RB)) begin
                byteBuf_d[i] = rawBytes[$clog2(RB)'(i - baseInt)];
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q + (accept ? CW'(RB) : '0) - (consume ? beatN : '0);
        portNum_d   = portNum_q;
        memBytes_d  = memBytes_q;
        pixData_d   = pixData_q;
        pixValid_d  = consume;
        underflow_d = underflow_q | (PIX_REQ_I & ~SOF_I & ~consume);

        if (consume) begin
            pixData_d = '0;
            for (int p = 0; p < C_MAX_PORT_NUM; p++) begin
                for (int b = 0; b < C_DDR_PIXEL_MAX_BYTE_NUM; b++) begin
                    if ((p < int'(portNum_q)) && (b < int'(memBytes_q))) begin
                        pixData_d[p*LW + b*8 +: 8] = byteBuf_q[AW'(p * int'(memBytes_q) + b)];
                    end
                end
            end
        end

        // Start of frame flushes residue and takes a clamped new configuration.
        if (SOF_I) begin
            cnt_d       = '0;
            underflow_d = 1'b0;
            pixValid_d  = 1'b0;
            if (CFG_PORT_NUM_I == 4'd0) begin
                portNum_d = 4'd1;
            end else if (CFG_PORT_NUM_I > 4'(C_MAX_PORT_NUM)) begin
                portNum_d = 4'(C_MAX_PORT_NUM);
            end else begin
                portNum_d = CFG_PORT_NUM_I;
            end
            if ((CFG_MEM_BYTES_I == 3'd0) || (CFG_MEM_BYTES_I > 3'(C_DDR_PIXEL_MAX_BYTE_NUM))) begin
                memBytes_d = 3'(C_DDR_PIXEL_MAX_BYTE_NUM);
            end else begin
                memBytes_d = CFG_MEM_BYTES_I;
            end
        end
    end

    always_ff @(posedge VID_CLK_I or negedge VID_RSTN_I) begin
        if (!VID_RSTN_I) begin
            for (int i = 0; i < DEPTH; i++) begin
                byteBuf_q[i] <= '0;
            end
            cnt_q       <= '0;
            portNum_q   <= 4'(C_MAX_PORT_NUM);
            memBytes_q  <= 3'(C_DDR_PIXEL_MAX_BYTE_NUM);
            pixData_q   <= '0;
            pixValid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                byteBuf_q[i] <= byteBuf_d[i];
            end
            cnt_q       <= cnt_d;
            portNum_q   <= portNum_d;
            memBytes_q  <= memBytes_d;
            pixData_q   <= pixData_d;
            pixValid_q  <= pixValid_d;
            underflow_q <= underflow_d;
        end
    end

    assign PIX_DATA_O  = pixData_q;
    assign PIX_VALID_O = pixValid_q;
    assign UNDERFLOW_O = underflow_q;

endmodule

// File: tb/tb_fb_raw_pixel_unpack.sv
// Bench for fb_raw_pixel_unpack: directed scenarios plus random traffic, all
// compared against a byte-queue reference model.
module tb_fb_raw_pixel_unpack;

    localparam int RW   = 256;
    localparam int RB   = RW / 8;
    localparam int MAXP = 4;
    localparam int MAXB = 4;
    localparam int LW   = MAXB * 8;
    localparam int DW   = LW * MAXP;

    logic          clk = 1'b0;
    logic          rstN;
    logic [3:0]    cfgPort;
    logic [2:0]    cfgMem;
    logic          sof;
    logic [RW-1:0] rawData;
    logic          rawValid;
    logic          rawReady;
    logic          pixReq;
    logic [DW-1:0] pixData;
    logic          pixValid;
    logic          underflow;

    always #5 clk = ~clk;

    fb_raw_pixel_unpack #(
        .C_RAW_DATA_WIDTH(RW),
        .C_MAX_PORT_NUM(MAXP),
        .C_DDR_PIXEL_MAX_BYTE_NUM(MAXB)
    ) dut (
        .VID_CLK_I(clk),
        .VID_RSTN_I(rstN),
        .CFG_PORT_NUM_I(cfgPort),
        .CFG_MEM_BYTES_I(cfgMem),
        .SOF_I(sof),
        .RAW_DATA_I(rawData),
        .RAW_VALID_I(rawValid),
        .RAW_READY_O(rawReady),
        .PIX_REQ_I(pixReq),
        .PIX_DATA_O(pixData),
        .PIX_VALID_O(pixValid),
        .UNDERFLOW_O(underflow)
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Reference model: a plain byte FIFO plus the latched configuration.
    byte unsigned  mq[$];
    int            mPort;
    int            mMem;
    logic [DW-1:0] mData;
    logic          mValid;
    logic          mUf;
    logic          lastAcc;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPort  = MAXP;
        mMem   = MAXB;
        mData  = '0;
        mValid = 1'b0;
        mUf    = 1'b0;
    endtask

    function automatic logic [RW-1:0] incWord(input int k);
        logic [RW-1:0] w;
        for (int b = 0; b < RB; b++) w[b*8 +: 8] = 8'(k * RB + b);
        return w;
    endfunction

    function automatic logic [RW-1:0] randWord();
        logic [RW-1:0] w;
        for (int i = 0; i < RW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Drives one clock cycle of inputs, advances the model, and checks every output.
    task automatic applyStimulus(input logic s, input logic v, input logic r, input string tag);
        int n;
        logic rdy, acc, cons;
        byte unsigned beat[$];
        sof = s; rawValid = v; pixReq = r;
        #1;
        n    = mPort * mMem;
        rdy  = (mq.size() <= RB) && !s;
        checkOutput({tag, "/ready"}, DW'(rawReady), DW'(rdy));
        acc  = v && rdy;
        cons = r && !s && (mq.size() >= n);
        @(posedge clk);
        #1;
        if (s) begin
            mq.delete();
            mUf    = 1'b0;
            mValid = 1'b0;
            mPort  = (cfgPort == 0) ? 1 : ((int'(cfgPort) > MAXP) ? MAXP : int'(cfgPort));
            mMem   = ((cfgMem == 0) || (int'(cfgMem) > MAXB)) ? MAXB : int'(cfgMem);
        end else begin
            mValid = cons;
            if (cons) begin
                for (int i = 0; i < n; i++) beat.push_back(mq.pop_front());
                mData = '0;
                for (int p = 0; p < mPort; p++)
                    for (int b = 0; b < mMem; b++)
                        mData[p*LW + b*8 +: 8] = beat[p*mMem + b];
            end else if (r) begin
                mUf = 1'b1;
            end
            if (acc) for (int b = 0; b < RB; b++) mq.push_back(rawData[b*8 +: 8]);
        end
        lastAcc = acc;
        checkOutput({tag, "/valid"}, DW'(pixValid), DW'(mValid));
        checkOutput({tag, "/underflow"}, DW'(underflow), DW'(mUf));
        checkOutput({tag, "/data"}, pixData, mData);
    endtask

    initial begin
        int wordsSent;
        rstN = 1'b0; cfgPort = 4'd4; cfgMem = 3'd4; sof = 1'b0;
        rawData = '0; rawValid = 1'b0; pixReq = 1'b0; lastAcc = 1'b0;
        modelReset();
        #3;
        checkOutput("reset/data", pixData, '0);
        checkOutput("reset/valid", DW'(pixValid), '0);
        checkOutput("reset/underflow", DW'(underflow), '0);
        #19 rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset/ready", DW'(rawReady), DW'(1'b1));

        $display("[TB] aligned packing");
        cfgPort = 4'd4; cfgMem = 3'd4;
        applyStimulus(1, 0, 0, "alignSof");
        rawData = {4{64'h0015954c0055954c}};
        applyStimulus(0, 1, 0, "alignFeed");
        rawData = randWord();
        applyStimulus(0, 0, 1, "alignBeat1");
        checkOutput("alignBeat1/const", pixData, {32'h0015954c, 32'h0055954c, 32'h0015954c, 32'h0055954c});
        applyStimulus(0, 0, 1, "alignBeat2");
        checkOutput("alignBeat2/const", pixData, {32'h0015954c, 32'h0055954c, 32'h0015954c, 32'h0055954c});
        applyStimulus(0, 0, 1, "alignBeat3");
        checkOutput("alignBeat3/uf", DW'(underflow), DW'(1'b1));

        $display("[TB] unaligned packing");
        cfgPort = 4'd4; cfgMem = 3'd3;
        applyStimulus(1, 0, 0, "unalSof");
        rawData = incWord(0);
        applyStimulus(0, 1, 0, "unalFeed");
        wordsSent = 1;
        for (int it = 0; it < 12; it++) begin
            rawData = incWord(wordsSent);
            applyStimulus(0, wordsSent < 3, 1, "unal");
            if (lastAcc) wordsSent++;
            if (it == 0) checkOutput("unalBeat0/lane0", DW'(pixData[31:0]), DW'(32'h00020100));
            if (it == 2) checkOutput("unalBeat2/lane3", DW'(pixData[127:96]), DW'(32'h00232221));
        end
        checkOutput("unal/empty", DW'(mq.size()), '0);

        $display("[TB] back-pressure");
        cfgPort = 4'd4; cfgMem = 3'd4;
        applyStimulus(1, 0, 0, "bpSof");
        for (int i = 0; i < 3; i++) begin
            rawData = randWord();
            applyStimulus(0, 1, 0, "bpFill");
        end
        #1 checkOutput("bp/full", DW'(rawReady), DW'(1'b0));
        applyStimulus(0, 1, 1, "bpReq1");
        #1 checkOutput("bp/48", DW'(rawReady), DW'(1'b0));
        applyStimulus(0, 1, 1, "bpReq2");
        rawValid = 1'b0;
        #1 checkOutput("bp/32", DW'(rawReady), DW'(1'b1));

        $display("[TB] simultaneous accept and consume");
        cfgPort = 4'd4; cfgMem = 3'd3;
        applyStimulus(1, 0, 0, "simSof");
        rawData = incWord(1);
        applyStimulus(0, 1, 0, "simFeed");
        applyStimulus(0, 0, 1, "simReq");
        rawData = incWord(4);
        applyStimulus(0, 1, 1, "simBoth");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, "simDrain");
        applyStimulus(0, 0, 1, "simUf");

        $display("[TB] SOF mid-frame");
        cfgPort = 4'd2; cfgMem = 3'd3;
        rawData = randWord();
        applyStimulus(1, 1, 1, "midSof");
        checkOutput("midSof/valid", DW'(pixValid), '0);
        checkOutput("midSof/uf", DW'(underflow), '0);
        rawData = randWord();
        applyStimulus(0, 1, 0, "midFeed");
        applyStimulus(0, 0, 1, "midBeat");
        checkOutput("midBeat/upper", DW'(pixData[127:64]), '0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            cfgPort = 4'($urandom_range(0, 15));
            cfgMem  = 3'($urandom_range(0, 7));
            rawData = randWord();
            applyStimulus($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), "rand");
        end

        $display("[TB] async reset");
        rawData = randWord();
        applyStimulus(0, 1, 1, "preRst");
        sof = 1'b0; rawValid = 1'b1; pixReq = 1'b1;
        #3 rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("rst/data", pixData, '0);
        checkOutput("rst/valid", DW'(pixValid), '0);
        checkOutput("rst/underflow", DW'(underflow), '0);
        rawValid = 1'b0; pixReq = 1'b0;
        #10 rstN = 1'b1;
        @(posedge clk); #1;
        rawData = incWord(0);
        applyStimulus(0, 1, 0, "postRstFeed");
        applyStimulus(0, 0, 1, "postRstBeat");
        checkOutput("postRst/lane0", DW'(pixData[31:0]), DW'(32'h03020100));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
